serial_rx_axis_packer: RTL and testbench
========================================

Name: serial_rx_axis_packer

Overview:
- Upstream source for the 32-bit TX AXI-stream of the FT232H 245-FIFO controller (TX_EW=2).
- Captures a slow external two-wire serial link (strobe plus data, e.g. the board's auxiliary clk/data pins) in the system clock domain.
- Assembles bits MSB-first into bytes, then packs bytes little-endian into 32-bit words with tkeep/tlast.
- Words stream to the host; a partial word is flushed with tlast on an idle timeout or at a packet boundary.

Parameters:
- TIMEOUT, 60000, idle clk cycles with no serial strobe before a partial word is flushed with tlast (min 4).
- PKT_WORDS, 256, full words per packet; the PKT_WORDS-th word carries tlast=1 (min 1).
- SYNC_STAGES, 2, synchronizer flops on s_clk/s_data (min 2).

Ports:
- clk  input  1  system clock; all logic in this domain.
- rstn  input  1  asynchronous active-low reset.
- s_clk  input  1  external serial strobe, asynchronous; data sampled on its rising edge.
- s_data  input  1  external serial data, asynchronous.
- o_tready  input  1  downstream ready.
- o_tvalid  output  1  word valid.
- o_tdata  output  32  packed word; byte lane 0 = first byte received.
- o_tkeep  output  4  valid byte lanes, always contiguous from lane 0.
- o_tlast  output  1  end of packet.
- o_overflow  output  1  sticky; a word was dropped while the output register was full.
- o_drop_cnt  output  16  count of dropped words, saturating at 0xFFFF.

Behaviour:
- Reset (async, rstn=0) clears all state. Outputs: o_tvalid=0, o_tdata=0, o_tkeep=0, o_tlast=0, o_overflow=0, o_drop_cnt=0. Bit, byte, word and idle counters are all 0. Reset mid-byte or mid-word discards the partial data; no flush occurs.
- Sync: s_clk and s_data each pass through SYNC_STAGES flops, plus one extra flop on s_clk for edge detection.
  - Rising edge = synced s_clk is 1 and its delayed copy is 0.
  - On the edge, synced s_data is sampled.
  - Pin-to-sample latency is SYNC_STAGES+1 clk cycles.
  - s_clk high and low phases must each be at least 2 clk periods; faster input is unsupported.
- Bit assembly: shift_byte <= {shift_byte[6:0], bit}; bit_cnt counts 0..7. On the 8th bit the byte is written into lane byte_idx of the word buffer, keep[byte_idx] is set, and bit_cnt returns to 0.
- Word complete (4th byte lands):
  - The word is pushed to the output register with tkeep=4'hF.
  - tlast=1 if word_cnt==PKT_WORDS-1, and word_cnt then wraps to 0; otherwise word_cnt increments.
  - o_tvalid rises 1 cycle after the 32nd bit's sample cycle.
  - byte_idx and keep clear.
- Idle timeout:
  - idle_cnt resets to 0 on every rising edge and otherwise increments, saturating at TIMEOUT.
  - When idle_cnt reaches TIMEOUT, any incomplete byte (bit_cnt≠0) is discarded.
  - If byte_idx>0, the partial word is pushed with tkeep = lanes filled, unused lanes of tdata = 0, and tlast=1; word_cnt resets to 0.
  - If byte_idx==0, nothing is emitted, but word_cnt still resets to 0.
  - A flush happens once per idle period.
- Output register, one entry:
  - Loaded when empty (o_tvalid=0), or when the current word is accepted (o_tvalid && o_tready) in the same cycle as the push. This gives back-to-back with no bubble.
  - o_tdata, o_tkeep and o_tlast are held stable while o_tvalid && !o_tready.
  - o_tvalid drops the cycle after acceptance if no push coincides.
- Overflow: a push while o_tvalid && !o_tready drops the new word. o_overflow is set and held until reset; o_drop_cnt increments, saturating. word_cnt still advances, so packet framing stays aligned to received words.
- Simultaneous events: a rising edge on the same cycle idle_cnt would hit TIMEOUT is treated as an edge; no flush occurs.

Test Plan:
- Serial bytes 0x11,0x22,0x33,0x44 with o_tready=1 -> one beat: tdata=0x44332211, tkeep=4'hF, tlast=0; o_tvalid arrives 1 cycle after the last bit's sample.
- Bytes 0xA5,0x3C, then idle TIMEOUT cycles -> tdata=0x00003CA5, tkeep=4'h3, tlast=1. A further idle period emits nothing.
- PKT_WORDS=2, 8 bytes 0x01..0x08 -> beats 0x04030201 (tlast=0) and 0x08070605 (tlast=1). The next 4 bytes give tlast=0.
- o_tready=0 while 12 bytes arrive -> first word held stable; words 2 and 3 dropped; o_overflow=1, o_drop_cnt=2. Raising o_tready delivers the first word only.
- o_tready toggling on each beat during a continuous 16-byte stream -> 4 beats in order, no drops, no duplicates.
- rstn pulsed low after 13 bits -> outputs return to 0. The next 32 bits produce a clean word with no residue from before the reset.

Source files
------------

// File: rtl/serial_rx_axis_packer.sv
// Two-wire serial receiver: synchronizes strobe/data into clk, assembles MSB-first bytes,
// and packs them little-endian into 32-bit AXI-stream words with tkeep/tlast framing.
module serial_rx_axis_packer #(
    parameter int TIMEOUT     = 60000,
    parameter int PKT_WORDS   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_clk,
    input  logic        s_data,
    input  logic        o_tready,
    output logic        o_tvalid,
    output logic [31:0] o_tdata,
    output logic [3:0]  o_tkeep,
    output logic        o_tlast,
    output logic        o_overflow,
    output logic [15:0] o_drop_cnt
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int WCNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PKT_WORDS - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_dly;
    logic                   rise;
    logic                   bit_in;

    logic [6:0]        shift_bits;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic [2:0]        lane_keep;
    logic [WCNT_W-1:0] word_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic [7:0]  new_byte;
    logic        byte_done;
    logic        word_done;
    logic        timeout_hit;
    logic        push;
    logic [31:0] push_data;
    logic [3:0]  push_keep;
    logic        push_last;
    logic        accept;
    logic        load;
    logic        drop;

    // Both pins go through equal-length chains so data stays aligned with its strobe.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_dly   <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], s_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], s_data};
            clk_dly   <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign rise   = clk_sync[SYNC_STAGES-1] & ~clk_dly;
    assign bit_in = data_sync[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        new_byte    = {shift_bits, bit_in};
        byte_done   = rise && (bit_cnt == 3'd7);
        word_done   = byte_done && (byte_idx == 2'd3);
        timeout_hit = !rise && (idle_cnt == IDLE_LAST);
        push        = 1'b0;
        push_data   = '0;
        push_keep   = '0;
        push_last   = 1'b0;
        if (word_done) begin
            push      = 1'b1;
            push_data = {new_byte, word_buf};
            push_keep = 4'hF;
            push_last = (word_cnt == WCNT_LAST);
        end else if (timeout_hit && (byte_idx != 2'd0)) begin
            push      = 1'b1;
            push_data = {8'h00, word_buf};
            push_keep = {1'b0, lane_keep};
            push_last = 1'b1;
        end
    end

    assign accept = o_tvalid && o_tready;
    assign load   = push && (!o_tvalid || o_tready);
    assign drop   = push && o_tvalid && !o_tready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_bits <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            lane_keep  <= '0;
            word_cnt   <= '0;
        end else if (rise) begin
            shift_bits <= new_byte[6:0];
            bit_cnt    <= bit_cnt + 3'd1;
            if (word_done) begin
                byte_idx  <= '0;
                word_buf  <= '0;
                lane_keep <= '0;
                word_cnt  <= (word_cnt == WCNT_LAST) ? '0 : word_cnt + 1'b1;
            end else if (byte_done) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    begin word_buf[7:0]   <= new_byte; lane_keep[0] <= 1'b1; end
                    2'd1:    begin word_buf[15:8]  <= new_byte; lane_keep[1] <= 1'b1; end
                    default: begin word_buf[23:16] <= new_byte; lane_keep[2] <= 1'b1; end
                endcase
            end
        end else if (timeout_hit) begin
            // Idle flush: drop any half-received byte and restart packet framing.
            bit_cnt   <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            lane_keep <= '0;
            word_cnt  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt <= '0;
        end else if (rise) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Single-entry output register; reloading on acceptance gives back-to-back beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tkeep  <= '0;
            o_tlast  <= 1'b0;
        end else if (load) begin
            o_tvalid <= 1'b1;
            o_tdata  <= push_data;
            o_tkeep  <= push_keep;
            o_tlast  <= push_last;
        end else if (accept) begin
            o_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else if (drop) begin
            o_overflow <= 1'b1;
            if (o_drop_cnt != 16'hFFFF) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_axis_packer.sv
// Directed + randomized bench for serial_rx_axis_packer, checked against a transaction-level
// model of bytes, words, packets and the single-entry output slot.
module tb_serial_rx_axis_packer;

    localparam int TIMEOUT     = 64;
    localparam int PKT_WORDS   = 2;
    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_clk;
    logic        s_data;
    logic        o_tready;
    logic        o_tvalid;
    logic [31:0] o_tdata;
    logic [3:0]  o_tkeep;
    logic        o_tlast;
    logic        o_overflow;
    logic [15:0] o_drop_cnt;

    serial_rx_axis_packer #(
        .TIMEOUT    (TIMEOUT),
        .PKT_WORDS  (PKT_WORDS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_clk     (s_clk),
        .s_data    (s_data),
        .o_tready  (o_tready),
        .o_tvalid  (o_tvalid),
        .o_tdata   (o_tdata),
        .o_tkeep   (o_tkeep),
        .o_tlast   (o_tlast),
        .o_overflow(o_overflow),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int hold_err = 0;

    beat_t      exp_q[$];
    beat_t      got_q[$];
    logic [7:0] cur[$];
    int         mdl_wcnt  = 0;
    int         mdl_drops = 0;
    bit         stalled   = 0;
    bit         slot_full = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic beat_t form_beat(input bit full);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < cur.size(); i++) b.data[8*i +: 8] = cur[i];
        b.keep = 4'((1 << cur.size()) - 1);
        b.last = full ? (mdl_wcnt == PKT_WORDS - 1) : 1'b1;
        return b;
    endfunction

    task automatic mdl_emit(input beat_t b);
        if (stalled && slot_full) begin
            mdl_drops++;
        end else begin
            exp_q.push_back(b);
            if (stalled) slot_full = 1;
        end
    endtask

    task automatic mdl_byte(input logic [7:0] b);
        cur.push_back(b);
        if (cur.size() == 4) begin
            mdl_emit(form_beat(1'b1));
            mdl_wcnt = (mdl_wcnt + 1) % PKT_WORDS;
            cur.delete();
        end
    endtask

    task automatic mdl_idle();
        if (cur.size() != 0) mdl_emit(form_beat(1'b0));
        cur.delete();
        mdl_wcnt = 0;
    endtask

    // ---------------- monitor: accepted beats and hold stability ----------------
    always begin : monitor
        beat_t prev;
        bit    prev_stall;
        prev_stall = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rstn) begin
                if (prev_stall && !(o_tvalid && o_tdata === prev.data &&
                                    o_tkeep === prev.keep && o_tlast === prev.last))
                    hold_err++;
                if (o_tvalid && o_tready) got_q.push_back('{o_tdata, o_tkeep, o_tlast});
                prev_stall = o_tvalid && !o_tready;
                prev = '{o_tdata, o_tkeep, o_tlast};
            end else begin
                prev_stall = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input logic b, input bit chk_lat);
        s_data = b;
        s_clk  = 1'b0;
        repeat (3) @(negedge clk);
        s_clk = 1'b1;
        if (chk_lat) begin
            repeat (2) @(negedge clk);
            check("latency_before", 32'(o_tvalid), 32'd0);
            @(negedge clk);
            check("latency_at", 32'(o_tvalid), 32'd1);
        end else begin
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit chk_lat);
        for (int i = 7; i >= 0; i--) send_bit(b[i], chk_lat && (i == 0));
        mdl_byte(b);
    endtask

    task automatic idle(input int n);
        s_clk = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_flush();
        idle(TIMEOUT + 10);
        mdl_idle();
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && o_tvalid; k++) @(negedge clk);
        check("drain", 32'(o_tvalid), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_beats(input string tag);
        int n;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_keep%0d", tag, i), 32'(got_q[i].keep), 32'(exp_q[i].keep));
            check($sformatf("%s_last%0d", tag, i), 32'(got_q[i].last), 32'(exp_q[i].last));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(o_tvalid), 32'd0);
        check({tag, "_tdata"}, o_tdata, 32'd0);
        check({tag, "_tkeep"}, 32'(o_tkeep), 32'd0);
        check({tag, "_tlast"}, 32'(o_tlast), 32'd0);
        check({tag, "_overflow"}, 32'(o_overflow), 32'd0);
        check({tag, "_drop_cnt"}, 32'(o_drop_cnt), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit done;
        int nb;
        rstn     = 1'b0;
        s_clk    = 1'b0;
        s_data   = 1'b0;
        o_tready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rstn = 1'b1;
        idle(TIMEOUT + 10);

        // Full word with latency check on the final bit.
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 1);
        idle_flush();
        wait_drain();
        compare_beats("word1");

        // Partial word flushed on idle; a second idle period emits nothing.
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        idle_flush();
        wait_drain();
        compare_beats("partial");
        idle(TIMEOUT + 10);
        check("idle2_none", 32'(got_q.size()), 32'd0);

        // Packet framing: PKT_WORDS-th word carries tlast.
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        idle_flush();
        wait_drain();
        compare_beats("packet");

        // Back-pressure: first word held, later words dropped.
        o_tready  = 1'b0;
        stalled   = 1;
        slot_full = 0;
        for (int i = 0; i < 12; i++) send_byte(8'($urandom), 0);
        check("stall_tvalid", 32'(o_tvalid), 32'd1);
        check("stall_tdata", o_tdata, exp_q[0].data);
        check("stall_tkeep", 32'(o_tkeep), 32'(exp_q[0].keep));
        check("overflow", 32'(o_overflow), 32'(mdl_drops != 0));
        check("drop_cnt", 32'(o_drop_cnt), 32'(mdl_drops));
        o_tready  = 1'b1;
        stalled   = 0;
        slot_full = 0;
        idle_flush();
        wait_drain();
        compare_beats("stall");

        // Randomly toggling ready during a continuous 16-byte stream.
        done = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) send_byte(8'($urandom), 0);
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    o_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        o_tready = 1'b1;
        idle_flush();
        wait_drain();
        compare_beats("toggle");
        check("toggle_drops", 32'(o_drop_cnt), 32'(mdl_drops));

        // Reset after 13 bits discards partial data and sticky status.
        for (int i = 0; i < 13; i++) send_bit(1'($urandom), 0);
        s_clk = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("midreset");
        cur.delete();
        mdl_wcnt  = 0;
        mdl_drops = 0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        idle_flush();
        wait_drain();
        compare_beats("post_reset");
        check("post_reset_drops", 32'(o_drop_cnt), 32'd0);

        // Random partial words of 1..3 bytes.
        for (int it = 0; it < 3; it++) begin
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) send_byte(8'($urandom), 0);
            idle_flush();
            wait_drain();
            compare_beats($sformatf("rand_partial%0d", it));
        end

        check("hold_stable", 32'(hold_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
